// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2/stride-2 streaming max-pool controller:
// FSM state encoding and the width rules used by the signed max compare.
package maxpool_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // A signed max returns one of its operands, so the result never needs a guard bit.
   localparam int MaxGrowthBits = 0;

   function automatic int max_out_width(input int data_width);
      return data_width + MaxGrowthBits;
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/max2_signed.sv
// Combinational two-input signed maximum; on a tie operand a is returned (same value).
module max2_signed
   import maxpool_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic signed [DATA_WIDTH-1:0]                a,
   input  logic signed [DATA_WIDTH-1:0]                b,
   output logic signed [max_out_width(DATA_WIDTH)-1:0] y
);

   assign y = (a >= b) ? a : b;

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Streaming 2x2 stride-2 signed max-pool over Depth planes of InputH x InputW pixels.
// Optional build macro MAXPOOL_RELU_EN clamps negative pooled results to zero.
module maxpool_stream_ctrl
   import maxpool_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int InputH     = 28,
   parameter int InputW     = 28,
   parameter int Depth      = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            dbg_state
);

   localparam int CW  = cnt_width(InputW);
   localparam int RW  = cnt_width(InputH);
   localparam int PW  = cnt_width(Depth);
   localparam int LbN = InputW / 2;
   localparam int LbW = cnt_width(LbN);

   if ((InputH % 2) != 0 || InputH < 2 || (InputW % 2) != 0 || InputW < 2) begin : g_bad_dims
      $error("maxpool_stream_ctrl: InputH and InputW must be even and at least 2");
   end

   // Handshakes: a beat transfers on a rising edge where valid && ready; a source
   // holds valid and data steady until that edge, and ready may depend on valid.

   state_e                state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [PW-1:0]         plane_q, plane_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] pair_q, pair_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;

   logic [DATA_WIDTH-1:0] line_q [LbN];
   logic [LbW-1:0]        lb_idx;
   logic [DATA_WIDTH-1:0] lb_rd;
   logic                  lb_we;

   logic                  beat;
   logic                  last_col, last_row, last_plane, last_beat;
   logic                  load;
   logic [DATA_WIDTH-1:0] pair_max;
   logic [DATA_WIDTH-1:0] quad_max;
   logic [DATA_WIDTH-1:0] pooled;

   assign in_ready   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign beat       = in_valid && in_ready;
   assign last_col   = (col_q == CW'(InputW - 1));
   assign last_row   = (row_q == RW'(InputH - 1));
   assign last_plane = (plane_q == PW'(Depth - 1));
   assign last_beat  = beat && last_col && last_row && last_plane;
   assign lb_idx     = LbW'(col_q >> 1);
   assign lb_rd      = line_q[lb_idx];
   assign lb_we      = beat && col_q[0] && !row_q[0];
   assign load       = beat && col_q[0] && row_q[0];

   max2_signed #(.DATA_WIDTH(DATA_WIDTH)) u_max_pair (
      .a (pair_q),
      .b (in_data),
      .y (pair_max)
   );

   max2_signed #(.DATA_WIDTH(DATA_WIDTH)) u_max_quad (
      .a (lb_rd),
      .b (pair_max),
      .y (quad_max)
   );

   always_comb begin
      pooled = quad_max;
`ifdef MAXPOOL_RELU_EN
      if (quad_max[DATA_WIDTH-1]) begin
         pooled = '0;
      end
`endif
   end

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      plane_d = plane_q;
      if (state_q == ST_IDLE && start) begin
         col_d   = '0;
         row_d   = '0;
         plane_d = '0;
      end else if (beat) begin
         if (last_col) begin
            col_d = '0;
            if (last_row) begin
               row_d   = '0;
               plane_d = last_plane ? '0 : plane_q + 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      pair_d      = (beat && !col_q[0]) ? in_data : pair_q;
      out_data_d  = load ? pooled : out_data_q;
      out_valid_d = out_valid_q;
      if (load) begin
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (last_beat) state_d = ST_FLUSH;
         ST_FLUSH: if (!out_valid_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         plane_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pair_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         plane_q     <= plane_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pair_q      <= pair_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Line buffer is never cleared: each entry is written on an even row before its odd-row read.
   always_ff @(posedge clk) begin
      if (lb_we) begin
         line_q[lb_idx] <= pair_max;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Self-checking bench for maxpool_stream_ctrl (4x4x2): randomized frames compared
// against a 2x2 window reference model; honours MAXPOOL_RELU_EN in the model.
module tb_maxpool_stream_ctrl;

   localparam int DW   = 16;
   localparam int H    = 4;
   localparam int W    = 4;
   localparam int D    = 2;
   localparam int NPIX = H * W * D;
   localparam int NOUT = (H / 2) * (W / 2) * D;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int ready_mode = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] frame [NPIX];

`ifdef MAXPOOL_RELU_EN
   int dir_tab [NOUT] = '{5, 7, 13, 15, 0, 0, 0, 0};
`else
   int dir_tab [NOUT] = '{5, 7, 13, 15, 0, -2, -8, -10};
`endif

   always #5 clk = ~clk;

   maxpool_stream_ctrl #(
      .DATA_WIDTH (DW),
      .InputH     (H),
      .InputW     (W),
      .Depth      (D)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
      end
   endtask

   // Output scoreboard capture and done pulse counting, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) got_q.push_back(out_data);
      if (reset_n && done) done_cnt++;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: sim time limit hit, required finish before it");
      $fatal(1, "watchdog expired");
   end

   // Reference: each output is the signed max over its 2x2 window, raster order, plane-major.
   function automatic logic [DW-1:0] pool_ref(input int p, input int r2, input int c2);
      int best;
      int v;
      best = -(1 << 30);
      for (int dr = 0; dr < 2; dr++) begin
         for (int dc = 0; dc < 2; dc++) begin
            v = int'($signed(frame[p * H * W + (2 * r2 + dr) * W + 2 * c2 + dc]));
            if (v > best) best = v;
         end
      end
`ifdef MAXPOOL_RELU_EN
      if (best < 0) best = 0;
`endif
      return DW'(best);
   endfunction

   task automatic build_expected();
      exp_q.delete();
      for (int p = 0; p < D; p++)
         for (int r = 0; r < H / 2; r++)
            for (int c = 0; c < W / 2; c++)
               exp_q.push_back(pool_ref(p, r, c));
   endtask

   task automatic send_pix(input logic [DW-1:0] v);
      int budget = 0;
      in_data  = v;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 300) check("in_ready timeout", DW'(0), DW'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " busy"}, DW'(busy), 16'd0);
      check({tag, " done"}, DW'(done), 16'd0);
      check({tag, " in_ready"}, DW'(in_ready), 16'd0);
      check({tag, " out_valid"}, DW'(out_valid), 16'd0);
      check({tag, " out_data"}, out_data, 16'd0);
      check({tag, " state"}, DW'(dbg_state), 16'd0);
   endtask

   task automatic run_frame(input string tag, input int gap_max, input bit poke_start);
      int base_done;
      int budget;
      build_expected();
      got_q.delete();
      base_done = done_cnt;
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, " busy after start"}, DW'(busy), 16'd1);
      for (int i = 0; i < NPIX; i++) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
         end
         if (poke_start && i == NPIX / 2) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         send_pix(frame[i]);
      end
      budget = 0;
      while (done_cnt == base_done && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      repeat (3) @(negedge clk);
      check({tag, " done pulses"}, DW'(done_cnt - base_done), 16'd1);
      check({tag, " busy after done"}, DW'(busy), 16'd0);
      check({tag, " idle after done"}, DW'(dbg_state), 16'd0);
      check({tag, " output count"}, DW'(got_q.size()), DW'(NOUT));
      for (int k = 0; k < NOUT; k++)
         check($sformatf("%s out[%0d]", tag, k),
               (k < got_q.size()) ? got_q[k] : {DW{1'bx}}, exp_q[k]);
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < H * W; i++) begin
         frame[i]         = DW'(i);
         frame[H * W + i] = DW'(-i);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Ramp plane followed by its negation; also against a fixed table.
      ready_mode = 0;
      fill_ramp();
      run_frame("ramp", 0, 0);
      for (int k = 0; k < NOUT; k++)
         check($sformatf("ramp table[%0d]", k),
               (k < got_q.size()) ? got_q[k] : {DW{1'bx}}, DW'(dir_tab[k]));

      // Downstream stall: output held, input blocked, nothing lost.
      ready_mode = 2;
      for (int i = 0; i < NPIX; i++) frame[i] = DW'($urandom_range(0, 65535));
      fork
         run_frame("stall", 0, 0);
         begin
            int budget = 0;
            while (!out_valid && budget < 200) begin
               @(negedge clk);
               budget++;
            end
            check("stall first valid", DW'(out_valid), 16'd1);
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               check("stall in_ready", DW'(in_ready), 16'd0);
               check("stall out_valid", DW'(out_valid), 16'd1);
               check("stall out_data", out_data, exp_q[0]);
            end
            ready_mode = 0;
         end
      join

      // Reset mid-frame after 6 beats, then a clean ramp frame.
      fill_ramp();
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 6; i++) send_pix(frame[i]);
      reset_n = 1'b0;
      #2;
      check_reset_state("mid reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      run_frame("after reset", 1, 0);

      // Start pulse while busy must be ignored.
      ready_mode = 1;
      for (int i = 0; i < NPIX; i++) frame[i] = DW'($urandom_range(0, 65535));
      run_frame("start while busy", 1, 1);

      // Random frames, including extreme signed values.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NPIX; i++) frame[i] = DW'($urandom_range(0, 65535));
         run_frame($sformatf("random%0d", f), 2, 0);
      end
      for (int i = 0; i < NPIX; i++) begin
         case ($urandom_range(0, 3))
            0:       frame[i] = 16'h8000;
            1:       frame[i] = 16'h7fff;
            2:       frame[i] = 16'hffff;
            default: frame[i] = 16'h0000;
         endcase
      end
      run_frame("extremes", 1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
